// File: rtl/rs_issue_queue.sv
// Age-ordered reservation station: holds instructions until operands wake, issues oldest ready.
// Optional RS_FLUSH_EN adds flush_i to discard all entries.
module rs_issue_queue #(
  parameter int RS_DEPTH = 8,
  parameter int TAG_W    = 6,
  parameter int ROB_W    = 5,
  localparam int CNT_W   = $clog2(RS_DEPTH + 1),
  localparam int IDX_W   = $clog2(RS_DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic [TAG_W-1:0] prs1_tag_i,
  input  logic [TAG_W-1:0] prs2_tag_i,
  input  logic             prs1_rdy_i,
  input  logic             prs2_rdy_i,
  input  logic [ROB_W-1:0] rob_idx_i,
  input  logic             cdb_en_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  output logic             issue_valid_o,
  input  logic             issue_ready_i,
  output logic [31:0]      issue_pc_o,
  output logic [31:0]      issue_inst_o,
  output logic [TAG_W-1:0] issue_prs1_tag_o,
  output logic [TAG_W-1:0] issue_prs2_tag_o,
  output logic [ROB_W-1:0] issue_rob_idx_o,
  output logic [CNT_W-1:0] count_o
`ifdef RS_FLUSH_EN
  ,
  input  logic             flush_i
`endif
);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic [ROB_W-1:0] rob;
    logic             r1;
    logic             r2;
  } entry_t;

  logic [RS_DEPTH-1:0] valid_q, valid_d;
  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] age_d [RS_DEPTH];
  logic [CNT_W-1:0]    count_q, count_d;

  logic [RS_DEPTH-1:0] ready;
  logic [RS_DEPTH-1:0] older_rdy;
  logic [RS_DEPTH-1:0] sel_oh;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                flush;
  logic                alloc_fire;
  logic                issue_fire;

`ifdef RS_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // age_q[j][i] set means j is older than i
  always_comb begin
    ready     = '0;
    older_rdy = '0;
    sel_oh    = '0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = valid_q[i] & ent_q[i].r1 & ent_q[i].r2;
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (ready[j] && age_q[j][i]) older_rdy[i] = 1'b1;
      end
      sel_oh[i] = ready[i] & ~older_rdy[i];
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign alloc_ready_o = (count_q != CNT_W'(RS_DEPTH)) & ~flush;
  assign issue_valid_o = (|sel_oh) & ~flush;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  assign issue_fire    = issue_valid_o & issue_ready_i;
  assign count_o       = count_q;

  always_comb begin
    issue_pc_o       = '0;
    issue_inst_o     = '0;
    issue_prs1_tag_o = '0;
    issue_prs2_tag_o = '0;
    issue_rob_idx_o  = '0;
    if (issue_valid_o) begin
      issue_pc_o       = ent_q[sel_idx].pc;
      issue_inst_o     = ent_q[sel_idx].inst;
      issue_prs1_tag_o = ent_q[sel_idx].t1;
      issue_prs2_tag_o = ent_q[sel_idx].t2;
      issue_rob_idx_o  = ent_q[sel_idx].rob;
    end
  end

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    age_d   = age_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid_q[i] && cdb_en_i) begin
        if (ent_q[i].t1 == cdb_tag_i) ent_d[i].r1 = 1'b1;
        if (ent_q[i].t2 == cdb_tag_i) ent_d[i].r2 = 1'b1;
      end
    end
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    if (alloc_fire) begin
      valid_d[free_idx]     = 1'b1;
      ent_d[free_idx].pc    = pc_i;
      ent_d[free_idx].inst  = inst_i;
      ent_d[free_idx].t1    = prs1_tag_i;
      ent_d[free_idx].t2    = prs2_tag_i;
      ent_d[free_idx].rob   = rob_idx_i;
      ent_d[free_idx].r1    = prs1_rdy_i |
                              (cdb_en_i && cdb_tag_i == prs1_tag_i);
      ent_d[free_idx].r2    = prs2_rdy_i |
                              (cdb_en_i && cdb_tag_i == prs2_tag_i);
      age_d[free_idx] = '0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        age_d[j][free_idx] = valid_q[j];
      end
    end
    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      ent_q   <= '{default: '0};
      age_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: reset, age order, bypass, full, backpressure, flush.
module tb_rs_issue_queue;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [31:0] pc_i, inst_i;
  logic [5:0]  prs1_tag_i, prs2_tag_i;
  logic        prs1_rdy_i, prs2_rdy_i;
  logic [4:0]  rob_idx_i;
  logic        cdb_en_i;
  logic [5:0]  cdb_tag_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [31:0] issue_pc_o, issue_inst_o;
  logic [5:0]  issue_prs1_tag_o, issue_prs2_tag_o;
  logic [4:0]  issue_rob_idx_o;
  logic [3:0]  count_o;
  logic        flush_i;

  int vecs = 0;
  int errs = 0;

  rs_issue_queue #(.RS_DEPTH(8), .TAG_W(6), .ROB_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .prs1_tag_i(prs1_tag_i), .prs2_tag_i(prs2_tag_i),
    .prs1_rdy_i(prs1_rdy_i), .prs2_rdy_i(prs2_rdy_i),
    .rob_idx_i(rob_idx_i), .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_pc_o(issue_pc_o), .issue_inst_o(issue_inst_o),
    .issue_prs1_tag_o(issue_prs1_tag_o),
    .issue_prs2_tag_o(issue_prs2_tag_o),
    .issue_rob_idx_o(issue_rob_idx_o),
    .count_o(count_o)
`ifdef RS_FLUSH_EN
    , .flush_i(flush_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [5:0] t1,
                       input logic r1, input logic [5:0] t2, input logic r2);
    alloc_valid_i = 1'b1;
    pc_i = pc; inst_i = ~pc; rob_idx_i = pc[6:2];
    prs1_tag_i = t1; prs1_rdy_i = r1;
    prs2_tag_i = t2; prs2_rdy_i = r2;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(); tick();
    vecs++; if (count_o !== 4'd0) begin errs++; $display("FAIL rst_count got %0d want 0", count_o); end
    vecs++; if (alloc_ready_o !== 1'b1) begin errs++; $display("FAIL rst_aready got %b want 1", alloc_ready_o); end
    vecs++; if (issue_valid_o !== 1'b0) begin errs++; $display("FAIL rst_ivalid got %b want 0", issue_valid_o); end
    vecs++; if (issue_pc_o !== 32'h0 || issue_rob_idx_o !== 5'd0) begin errs++; $display("FAIL rst_idata got %h want 0", issue_pc_o); end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive(32'h100, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    alloc_valid_i = 1'b0;
    vecs++; if (issue_valid_o !== 1'b1) begin errs++; $display("FAIL single_valid got %b want 1", issue_valid_o); end
    vecs++; if (issue_pc_o !== 32'h100) begin errs++; $display("FAIL single_pc got %h want 100", issue_pc_o); end
    vecs++; if (issue_inst_o !== ~32'h100 || issue_prs2_tag_o !== 6'd2) begin errs++; $display("FAIL single_fields got %h/%0d want %h/2", issue_inst_o, issue_prs2_tag_o, ~32'h100); end
    vecs++; if (count_o !== 4'd1) begin errs++; $display("FAIL single_count got %0d want 1", count_o); end
    issue_ready_i = 1'b1;
    tick();
    issue_ready_i = 1'b0;
    vecs++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0) begin errs++; $display("FAIL single_drain got %0d/%b want 0/0", count_o, issue_valid_o); end
  endtask

  task automatic load_abc();
    drive(32'hA0, 6'd5, 1'b0, 6'd1, 1'b1); tick();
    drive(32'hB0, 6'd1, 1'b1, 6'd2, 1'b1); tick();
    drive(32'hC0, 6'd1, 1'b1, 6'd2, 1'b1); tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic test_age();
    load_abc();
    vecs++; if (issue_pc_o !== 32'hB0) begin errs++; $display("FAIL age1_first got %h want b0", issue_pc_o); end
    issue_ready_i = 1'b1;
    tick();
    vecs++; if (issue_pc_o !== 32'hC0) begin errs++; $display("FAIL age1_second got %h want c0", issue_pc_o); end
    tick();
    vecs++; if (issue_valid_o !== 1'b0) begin errs++; $display("FAIL age1_stall got %b want 0", issue_valid_o); end
    cdb_en_i = 1'b1; cdb_tag_i = 6'd5;
    tick();
    cdb_en_i = 1'b0;
    vecs++; if (issue_pc_o !== 32'hA0) begin errs++; $display("FAIL age1_third got %h want a0", issue_pc_o); end
    tick();
    issue_ready_i = 1'b0;
    vecs++; if (count_o !== 4'd0) begin errs++; $display("FAIL age1_drain got %0d want 0", count_o); end
    load_abc();
    cdb_en_i = 1'b1; cdb_tag_i = 6'd5;
    #1;
    vecs++; if (issue_pc_o !== 32'hB0) begin errs++; $display("FAIL age2_cdb_comb got %h want b0", issue_pc_o); end
    tick();
    cdb_en_i = 1'b0;
    vecs++; if (issue_pc_o !== 32'hA0) begin errs++; $display("FAIL age2_first got %h want a0", issue_pc_o); end
    issue_ready_i = 1'b1;
    tick();
    vecs++; if (issue_pc_o !== 32'hB0) begin errs++; $display("FAIL age2_second got %h want b0", issue_pc_o); end
    tick();
    vecs++; if (issue_pc_o !== 32'hC0) begin errs++; $display("FAIL age2_third got %h want c0", issue_pc_o); end
    tick();
    issue_ready_i = 1'b0;
    vecs++; if (count_o !== 4'd0) begin errs++; $display("FAIL age2_drain got %0d want 0", count_o); end
  endtask

  task automatic test_bypass();
    drive(32'h90, 6'd9, 1'b0, 6'd3, 1'b1);
    cdb_en_i = 1'b1; cdb_tag_i = 6'd9;
    tick();
    alloc_valid_i = 1'b0; cdb_en_i = 1'b0;
    vecs++; if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h90) begin errs++; $display("FAIL bypass got %b/%h want 1/90", issue_valid_o, issue_pc_o); end
    issue_ready_i = 1'b1;
    tick();
    issue_ready_i = 1'b0;
    drive(32'h94, 6'd12, 1'b0, 6'd12, 1'b0);
    cdb_en_i = 1'b1; cdb_tag_i = 6'd11;
    tick();
    alloc_valid_i = 1'b0;
    vecs++; if (issue_valid_o !== 1'b0) begin errs++; $display("FAIL bypass_miss got %b want 0", issue_valid_o); end
    cdb_tag_i = 6'd12;
    tick();
    cdb_en_i = 1'b0;
    vecs++; if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h94) begin errs++; $display("FAIL dual_wake got %b/%h want 1/94", issue_valid_o, issue_pc_o); end
    issue_ready_i = 1'b1;
    tick();
    issue_ready_i = 1'b0;
    vecs++; if (count_o !== 4'd0) begin errs++; $display("FAIL bypass_drain got %0d want 0", count_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      drive(32'h200 + 32'(4 * i), 6'(40 + i), 1'b0, 6'd1, 1'b1);
      tick();
    end
    alloc_valid_i = 1'b0;
    vecs++; if (alloc_ready_o !== 1'b0 || count_o !== 4'd8) begin errs++; $display("FAIL full got %b/%0d want 0/8", alloc_ready_o, count_o); end
    cdb_en_i = 1'b1; cdb_tag_i = 6'd40;
    tick();
    cdb_en_i = 1'b0;
    vecs++; if (issue_pc_o !== 32'h200) begin errs++; $display("FAIL full_wake got %h want 200", issue_pc_o); end
    drive(32'h300, 6'd1, 1'b1, 6'd2, 1'b1);
    issue_ready_i = 1'b1;
    tick();
    issue_ready_i = 1'b0;
    vecs++; if (count_o !== 4'd7 || alloc_ready_o !== 1'b1) begin errs++; $display("FAIL full_nopass got %0d/%b want 7/1", count_o, alloc_ready_o); end
    tick();
    alloc_valid_i = 1'b0;
    vecs++; if (count_o !== 4'd8 || issue_pc_o !== 32'h300) begin errs++; $display("FAIL full_realloc got %0d/%h want 8/300", count_o, issue_pc_o); end
    issue_ready_i = 1'b1; cdb_en_i = 1'b1;
    for (int k = 0; k < 30 && count_o != 4'd0; k++) begin
      cdb_tag_i = 6'(41 + (k % 7));
      tick();
    end
    issue_ready_i = 1'b0; cdb_en_i = 1'b0;
    vecs++; if (count_o !== 4'd0) begin errs++; $display("FAIL full_drain got %0d want 0", count_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(32'h400 + 32'(4 * i), 6'd1, 1'b1, 6'd2, 1'b1);
      tick();
    end
    alloc_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vecs++; if (count_o !== 4'd3 || issue_pc_o !== 32'h400) begin errs++; $display("FAIL bp_hold%0d got %0d/%h want 3/400", c, count_o, issue_pc_o); end
    end
    issue_ready_i = 1'b1;
    tick();
    vecs++; if (count_o !== 4'd2 || issue_pc_o !== 32'h404) begin errs++; $display("FAIL b2b_1 got %0d/%h want 2/404", count_o, issue_pc_o); end
    tick();
    vecs++; if (count_o !== 4'd1 || issue_pc_o !== 32'h408) begin errs++; $display("FAIL b2b_2 got %0d/%h want 1/408", count_o, issue_pc_o); end
    tick();
    issue_ready_i = 1'b0;
    vecs++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0) begin errs++; $display("FAIL b2b_3 got %0d/%b want 0/0", count_o, issue_valid_o); end
  endtask

`ifdef RS_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      drive(32'h500 + 32'(4 * i), 6'd1, 1'b1, 6'd2, 1'b1);
      tick();
    end
    drive(32'h600, 6'd1, 1'b1, 6'd2, 1'b1);
    issue_ready_i = 1'b1;
    flush_i = 1'b1;
    #1;
    vecs++; if (alloc_ready_o !== 1'b0 || issue_valid_o !== 1'b0) begin errs++; $display("FAIL flush_comb got %b/%b want 0/0", alloc_ready_o, issue_valid_o); end
    tick();
    flush_i = 1'b0; alloc_valid_i = 1'b0; issue_ready_i = 1'b0;
    vecs++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0) begin errs++; $display("FAIL flush_clear got %0d/%b want 0/0", count_o, issue_valid_o); end
  endtask
`endif

  task automatic test_async_reset();
    drive(32'h700, 6'd1, 1'b1, 6'd2, 1'b1); tick();
    drive(32'h704, 6'd1, 1'b1, 6'd2, 1'b1); tick();
    alloc_valid_i = 1'b0;
    vecs++; if (count_o !== 4'd2) begin errs++; $display("FAIL ar_pre got %0d want 2", count_o); end
    #2 reset_i = 1'b1;
    #1;
    vecs++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0) begin errs++; $display("FAIL ar_state got %0d/%b want 0/0", count_o, issue_valid_o); end
    vecs++; if (alloc_ready_o !== 1'b1 || issue_pc_o !== 32'h0) begin errs++; $display("FAIL ar_outs got %b/%h want 1/0", alloc_ready_o, issue_pc_o); end
    #3 reset_i = 1'b0;
    tick();
    vecs++; if (count_o !== 4'd0) begin errs++; $display("FAIL ar_post got %0d want 0", count_o); end
  endtask

  initial begin
    reset_i = 1'b1; alloc_valid_i = 1'b0; issue_ready_i = 1'b0;
    pc_i = '0; inst_i = '0; prs1_tag_i = '0; prs2_tag_i = '0;
    prs1_rdy_i = 1'b0; prs2_rdy_i = 1'b0; rob_idx_i = '0;
    cdb_en_i = 1'b0; cdb_tag_i = '0; flush_i = 1'b0;
    test_reset();
    test_single();
    test_age();
    test_bypass();
    test_full();
    test_back_to_back();
`ifdef RS_FLUSH_EN
    test_flush();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
